// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle ARM controller and its shared datapath.
// instr is declared [31:12] so field slices keep their architectural bit numbers.
interface multicycle_controller_if #(
  parameter int unsigned ALUC_W = 2
);
  logic [31:12]      instr;
  logic [3:0]        alu_flags;
  logic              pc_write;
  logic              adr_src;
  logic              mem_write;
  logic              ir_write;
  logic [1:0]        result_src;
  logic [ALUC_W-1:0] alu_control;
  logic              alu_src_a;
  logic [1:0]        alu_src_b;
  logic [1:0]        imm_src;
  logic              reg_write;
  logic [1:0]        reg_src;

  // Controller side
  modport master (
    input  instr, alu_flags,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_control,
           alu_src_a, alu_src_b, imm_src, reg_write, reg_src
  );

  // Datapath side
  modport slave (
    output instr, alu_flags,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_control,
           alu_src_a, alu_src_b, imm_src, reg_write, reg_src
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: main FSM, ALU decode, NZCV flag register and
// condition check. Each instruction walks 3-5 states over a shared datapath.
module multicycle_controller #(
  parameter int unsigned ALUC_W      = 2,
  parameter bit          SUPPORT_CMP = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  // Internal ALU op is at least 3 bits wide so EOR (4) is representable.
  localparam int unsigned OpW = (ALUC_W > 3) ? ALUC_W : 3;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWr,
    StMemWb, StExecR, StExecI, StAluWb, StBranch
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     flags_q, flags_d;

  logic [3:0]     cond;
  logic [1:0]     op;
  logic           funct5;
  logic [3:0]     cmd;
  logic           s_bit;
  logic           rd_is_pc;
  logic [OpW-1:0] alu_op;
  logic [1:0]     flag_w;
  logic           no_write;
  logic           cond_ex;
  logic           in_exec;
  logic           unused_rn;

  assign cond      = bus.instr[31:28];
  assign op        = bus.instr[27:26];
  assign funct5    = bus.instr[25];
  assign cmd       = bus.instr[24:21];
  assign s_bit     = bus.instr[20];
  assign rd_is_pc  = (bus.instr[15:12] == 4'hf);
  assign unused_rn = ^bus.instr[19:16];
  assign in_exec   = (state_q == StExecR) || (state_q == StExecI);

  // State register: reset aborts the current instruction and returns to fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (op)
          2'b00:   state_d = funct5 ? StExecI : StExecR;
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = s_bit ? StMemRd : StMemWr;  // instr[20] is L for memory ops
      StMemRd:  state_d = StMemWb;
      StMemWr:  state_d = StFetch;
      StMemWb:  state_d = StFetch;
      StExecR:  state_d = StAluWb;
      StExecI:  state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // ALU operation decode and flag-write enables.
  always_comb begin
    alu_op = OpW'(0);
    case (cmd)
      4'b0100:          alu_op = OpW'(0);
      4'b0010, 4'b1010: alu_op = OpW'(1);
      4'b0000:          alu_op = OpW'(2);
      4'b1100:          alu_op = OpW'(3);
      4'b0001:          alu_op = (ALUC_W >= 3) ? OpW'(4) : OpW'(0);
      default:          alu_op = OpW'(0);
    endcase
    flag_w[1] = s_bit;
    flag_w[0] = s_bit && ((alu_op == OpW'(0)) || (alu_op == OpW'(1)));
    no_write  = SUPPORT_CMP && s_bit && (cmd == 4'b1010);
  end

  // ARM condition check against the registered flags {N,Z,C,V}.
  always_comb begin
    unique case (cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flag update at the end of an executed EXEC cycle; NZ and CV gated separately.
  always_comb begin
    flags_d = flags_q;
    if (in_exec && cond_ex) begin
      if (flag_w[1]) flags_d[3:2] = bus.alu_flags[3:2];
      if (flag_w[0]) flags_d[1:0] = bus.alu_flags[1:0];
    end
  end

  // Per-state control outputs; write enables are forced low while in reset.
  always_comb begin
    bus.pc_write    = 1'b0;
    bus.adr_src     = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.result_src  = 2'b00;
    bus.alu_control = '0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.reg_write   = 1'b0;
    bus.imm_src     = op;
    bus.reg_src     = {op == 2'b01, op == 2'b10};
    unique case (state_q)
      StFetch: begin
        bus.ir_write   = 1'b1;
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.pc_write   = 1'b1;
      end
      StDecode: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
      end
      StMemAdr: bus.alu_src_b = 2'b01;
      StMemRd:  bus.adr_src = 1'b1;
      StMemWr: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = cond_ex;
      end
      StMemWb: begin
        bus.result_src = 2'b01;
        if (rd_is_pc) bus.pc_write  = cond_ex;
        else          bus.reg_write = cond_ex;
      end
      StExecR: bus.alu_control = alu_op[ALUC_W-1:0];
      StExecI: begin
        bus.alu_src_b   = 2'b01;
        bus.alu_control = alu_op[ALUC_W-1:0];
      end
      StAluWb: begin
        if (rd_is_pc) bus.pc_write  = cond_ex;
        else          bus.reg_write = cond_ex & ~no_write;
      end
      StBranch: begin
        bus.alu_src_b  = 2'b01;
        bus.result_src = 2'b10;
        bus.pc_write   = cond_ex;
      end
      default: ;
    endcase
    if (!reset) begin
      bus.pc_write  = 1'b0;
      bus.mem_write = 1'b0;
      bus.ir_write  = 1'b0;
      bus.reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller. Two instances share stimulus:
// dut_a (ALUC_W=3, SUPPORT_CMP=1) and dut_b (ALUC_W=2, SUPPORT_CMP=0).
module tb_multicycle_controller;

  // {pcw, adr, mw, irw, rs[1:0], aluc[2:0], asa, asb[1:0], imm[1:0], rw, rsrc[1:0]}
  typedef logic [16:0] ctl_t;
  typedef struct {
    string name;
    ctl_t  exp_a;
    ctl_t  exp_b;
  } exp_t;

  // {imm_src, reg_src} per instruction class
  localparam logic [3:0] DP  = 4'b0000;
  localparam logic [3:0] MEM = 4'b0110;
  localparam logic [3:0] BR  = 4'b1001;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:12] instr;
  logic [3:0]   alu_flags;
  int           checks = 0;
  int           errors = 0;
  exp_t         sb_q[$];
  ctl_t         act_a, act_b;

  multicycle_controller_if #(.ALUC_W(3)) if_a ();
  multicycle_controller_if #(.ALUC_W(2)) if_b ();

  assign if_a.instr     = instr;
  assign if_a.alu_flags = alu_flags;
  assign if_b.instr     = instr;
  assign if_b.alu_flags = alu_flags;

  multicycle_controller #(.ALUC_W(3), .SUPPORT_CMP(1'b1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  multicycle_controller #(.ALUC_W(2), .SUPPORT_CMP(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  always #5 clk = ~clk;

  assign act_a = {if_a.pc_write, if_a.adr_src, if_a.mem_write, if_a.ir_write, if_a.result_src,
                  if_a.alu_control, if_a.alu_src_a, if_a.alu_src_b, if_a.imm_src,
                  if_a.reg_write, if_a.reg_src};
  assign act_b = {if_b.pc_write, if_b.adr_src, if_b.mem_write, if_b.ir_write, if_b.result_src,
                  1'b0, if_b.alu_control, if_b.alu_src_a, if_b.alu_src_b, if_b.imm_src,
                  if_b.reg_write, if_b.reg_src};

  function automatic ctl_t v(input bit pcw, input bit adr, input bit mw, input bit irw,
                             input bit [1:0] rs, input bit [2:0] aluc, input bit asa,
                             input bit [1:0] asb, input bit rw, input bit [3:0] ext);
    return {pcw, adr, mw, irw, rs, aluc, asa, asb, ext[3:2], rw, ext[1:0]};
  endfunction

  function automatic ctl_t fetch(input bit [3:0] ext);
    return v(1, 0, 0, 1, 2'b10, 3'd0, 1, 2'b10, 0, ext);
  endfunction

  // DECODE controls; also the output pattern expected while reset is low.
  function automatic ctl_t idle(input bit [3:0] ext);
    return v(0, 0, 0, 0, 2'b10, 3'd0, 1, 2'b10, 0, ext);
  endfunction

  task automatic push2(input string nm, input ctl_t a, input ctl_t b);
    exp_t e;
    e.name  = nm;
    e.exp_a = a;
    e.exp_b = b;
    sb_q.push_back(e);
  endtask

  task automatic push(input string nm, input ctl_t a);
    push2(nm, a, a);
  endtask

  task automatic cmp(input string nm, input ctl_t got, input ctl_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic chk_flags(input string nm, input logic [3:0] want);
    checks++;
    if (dut_a.flags_q !== want) begin
      errors++;
      $display("FAIL %s/a flags: got %b want %b", nm, dut_a.flags_q, want);
    end
    checks++;
    if (dut_b.flags_q !== want) begin
      errors++;
      $display("FAIL %s/b flags: got %b want %b", nm, dut_b.flags_q, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every falling edge with a pending expectation is compared.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cmp({e.name, "/a"}, act_a, e.exp_a);
      cmp({e.name, "/b"}, act_b, e.exp_b);
    end
  end

  // Stimulus: applied 1 time unit after a rising edge, when the FSM is in FETCH.
  initial begin
    reset     = 1'b0;
    instr     = 20'hE0921;
    alu_flags = 4'b0110;
    push("rst0", idle(DP));
    push("rst1", idle(DP));
    push("rst2", idle(DP));
    cyc(4);
    reset = 1'b1;

    // ADDS R1,R2,R3
    push("adds fetch", fetch(DP));
    push("adds decode", idle(DP));
    push("adds execr", v(0, 0, 0, 0, 2'b00, 3'd0, 0, 2'b00, 0, DP));
    push("adds aluwb", v(0, 0, 0, 0, 2'b00, 3'd0, 0, 2'b00, 1, DP));
    cyc(4);
    chk_flags("adds", 4'b0110);

    // CMP R1,#5: only dut_a suppresses the register write
    instr = 20'hE3510; alu_flags = 4'b0100;
    push("cmp fetch", fetch(DP));
    push("cmp decode", idle(DP));
    push("cmp execi", v(0, 0, 0, 0, 2'b00, 3'd1, 0, 2'b01, 0, DP));
    push2("cmp aluwb", v(0, 0, 0, 0, 2'b00, 3'd0, 0, 2'b00, 0, DP),
                       v(0, 0, 0, 0, 2'b00, 3'd0, 0, 2'b00, 1, DP));
    cyc(4);
    chk_flags("cmp", 4'b0100);

    // BEQ taken (Z=1); ALU flags outside EXEC must not load
    instr = 20'h0A000; alu_flags = 4'b1111;
    push("beq fetch", fetch(BR));
    push("beq decode", idle(BR));
    push("beq branch", v(1, 0, 0, 0, 2'b10, 3'd0, 0, 2'b01, 0, BR));
    cyc(3);
    chk_flags("beq", 4'b0100);

    // LDR R0,[R1,#4]
    instr = 20'hE5910;
    push("ldr fetch", fetch(MEM));
    push("ldr decode", idle(MEM));
    push("ldr memadr", v(0, 0, 0, 0, 2'b00, 3'd0, 0, 2'b01, 0, MEM));
    push("ldr memrd", v(0, 1, 0, 0, 2'b00, 3'd0, 0, 2'b00, 0, MEM));
    push("ldr memwb", v(0, 0, 0, 0, 2'b01, 3'd0, 0, 2'b00, 1, MEM));
    cyc(5);

    // STR R0,[R1,#4]
    instr = 20'hE5810;
    push("str fetch", fetch(MEM));
    push("str decode", idle(MEM));
    push("str memadr", v(0, 0, 0, 0, 2'b00, 3'd0, 0, 2'b01, 0, MEM));
    push("str memwr", v(0, 1, 1, 0, 2'b00, 3'd0, 0, 2'b00, 0, MEM));
    cyc(4);

    // ADDNE with Z=1: full path, no write, no flag change
    instr = 20'h10821; alu_flags = 4'b0011;
    push("addne fetch", fetch(DP));
    push("addne decode", idle(DP));
    push("addne execr", v(0, 0, 0, 0, 2'b00, 3'd0, 0, 2'b00, 0, DP));
    push("addne aluwb", v(0, 0, 0, 0, 2'b00, 3'd0, 0, 2'b00, 0, DP));
    cyc(4);
    chk_flags("addne", 4'b0100);

    // ADD PC,R2,R3: write redirected to PC
    instr = 20'hE082F;
    push("addpc fetch", fetch(DP));
    push("addpc decode", idle(DP));
    push("addpc execr", v(0, 0, 0, 0, 2'b00, 3'd0, 0, 2'b00, 0, DP));
    push("addpc aluwb", v(1, 0, 0, 0, 2'b00, 3'd0, 0, 2'b00, 0, DP));
    cyc(4);

    // EOR R0,R1,R2: op 4 with 3-bit control, ADD with 2-bit control
    instr = 20'hE0210;
    push("eor fetch", fetch(DP));
    push("eor decode", idle(DP));
    push2("eor execr", v(0, 0, 0, 0, 2'b00, 3'd4, 0, 2'b00, 0, DP),
                       v(0, 0, 0, 0, 2'b00, 3'd0, 0, 2'b00, 0, DP));
    push("eor aluwb", v(0, 0, 0, 0, 2'b00, 3'd0, 0, 2'b00, 1, DP));
    cyc(4);

    // BNE not taken (Z=1)
    instr = 20'h1A000;
    push("bne fetch", fetch(BR));
    push("bne decode", idle(BR));
    push("bne branch", v(0, 0, 0, 0, 2'b10, 3'd0, 0, 2'b01, 0, BR));
    cyc(3);

    // ANDS: NZ load, CV kept
    instr = 20'hE0121; alu_flags = 4'b1011;
    push("ands fetch", fetch(DP));
    push("ands decode", idle(DP));
    push("ands execr", v(0, 0, 0, 0, 2'b00, 3'd2, 0, 2'b00, 0, DP));
    push("ands aluwb", v(0, 0, 0, 0, 2'b00, 3'd0, 0, 2'b00, 1, DP));
    cyc(4);
    chk_flags("ands", 4'b1000);

    // ORR R1,R2,R3
    instr = 20'hE1821; alu_flags = 4'b0111;
    push("orr fetch", fetch(DP));
    push("orr decode", idle(DP));
    push("orr execr", v(0, 0, 0, 0, 2'b00, 3'd3, 0, 2'b00, 0, DP));
    push("orr aluwb", v(0, 0, 0, 0, 2'b00, 3'd0, 0, 2'b00, 1, DP));
    cyc(4);
    chk_flags("orr", 4'b1000);

    // STR aborted by reset in MEMWR, then rerun from FETCH
    instr = 20'hE5810;
    push("stra fetch", fetch(MEM));
    push("stra decode", idle(MEM));
    push("stra memadr", v(0, 0, 0, 0, 2'b00, 3'd0, 0, 2'b01, 0, MEM));
    cyc(3);
    reset = 1'b0;
    push("stra memwr rst", idle(MEM));
    cyc(1);
    chk_flags("rst", 4'b0000);
    reset = 1'b1;
    push("strb fetch", fetch(MEM));
    push("strb decode", idle(MEM));
    push("strb memadr", v(0, 0, 0, 0, 2'b00, 3'd0, 0, 2'b01, 0, MEM));
    push("strb memwr", v(0, 1, 1, 0, 2'b00, 3'd0, 0, 2'b00, 0, MEM));
    cyc(4);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
